// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU controller: opcode and condition encodings,
// NZCV bit positions and the controller FSM state type.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_EOR  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_RSB  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADC  = 5'd5;
    localparam logic [4:0] OP_SBC  = 5'd6;
    localparam logic [4:0] OP_RSC  = 5'd7;
    localparam logic [4:0] OP_TST  = 5'd8;
    localparam logic [4:0] OP_TEQ  = 5'd9;
    localparam logic [4:0] OP_CMP  = 5'd10;
    localparam logic [4:0] OP_CMN  = 5'd11;
    localparam logic [4:0] OP_ORR  = 5'd12;
    localparam logic [4:0] OP_MOV  = 5'd13;
    localparam logic [4:0] OP_BIC  = 5'd14;
    localparam logic [4:0] OP_MVN  = 5'd15;
    localparam logic [4:0] OP_IDLE = 5'b10000;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Compare/test ops update flags without writing a destination register.
    function automatic logic is_cmp(input logic [4:0] op);
        return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
    endfunction

    function automatic logic is_arith(input logic [4:0] op);
        return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
    endfunction

endpackage

// File: rtl/alu_ctrl_cond.sv
// Combinational ARM condition-code evaluation against an NZCV flag value.
module alu_cond_eval
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic c, z, v, n;

    assign c = flags[FLAG_C];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        // NOTE: default first so every path assigns pass and no latch is inferred.
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing controller for an external combinational ALU: captures one
// instruction, runs it for a single cycle, and owns the NZCV flag register.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [4:0]   req_op,
    input  logic [3:0]   req_cond,
    input  logic         req_s,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         req_shc,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [4:0]   alu_op,
    output logic         alu_cin,
    input  logic [W-1:0] alu_r,
    input  logic [3:0]   alu_flag,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_wr,
    output logic [3:0]   flags,
    input  logic         flag_ld,
    input  logic [3:0]   flag_in
);

    state_t       state, state_nxt;
    logic [4:0]   op_q;
    logic [3:0]   cond_q;
    logic         s_q, shc_q;
    logic [W-1:0] a_q, b_q;
    logic         pass, cmp, upd;
    logic [3:0]   flags_nxt;

    alu_cond_eval u_cond (
        .cond  (cond_q),
        .flags (flags),
        .pass  (pass)
    );

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        res_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = OP_IDLE;
        alu_cin   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                alu_a     = a_q;
                alu_b     = b_q;
                alu_op    = op_q;
                alu_cin   = flags[FLAG_C];
                state_nxt = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cmp = is_cmp(op_q);
    assign upd = (state == S_EXEC) && pass && (s_q || cmp) && !op_q[4];

    // The MSR-style external load overrides any instruction flag update.
    always_comb begin
        flags_nxt = flags;
        if (flag_ld) begin
            flags_nxt = flag_in;
        end else if (upd) begin
            if (is_arith(op_q)) begin
                flags_nxt = alu_flag;
            end else begin
                flags_nxt[FLAG_N] = alu_flag[FLAG_N];
                flags_nxt[FLAG_Z] = alu_flag[FLAG_Z];
                flags_nxt[FLAG_C] = shc_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= '0;
            cond_q   <= '0;
            s_q      <= 1'b0;
            shc_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            flags    <= '0;
            res_data <= '0;
            res_wr   <= 1'b0;
        end else begin
            state <= state_nxt;
            flags <= flags_nxt;
            if (req_valid && req_ready) begin
                op_q   <= req_op;
                cond_q <= req_cond;
                s_q    <= req_s;
                shc_q  <= req_shc;
                a_q    <= req_a;
                b_q    <= req_b;
            end
            if (state == S_EXEC) begin
                res_data <= alu_r;
                res_wr   <= pass & ~cmp;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: behavioural ALU attached to the alu_* ports,
// directed scenarios followed by randomized instructions against a flag/result model.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [4:0]  req_op;
    logic [3:0]  req_cond;
    logic        req_s, req_shc;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [4:0]  alu_op;
    logic        alu_cin;
    logic [3:0]  alu_flag;
    logic        res_valid, res_ready, res_wr;
    logic [31:0] res_data;
    logic [3:0]  flags;
    logic        flag_ld;
    logic [3:0]  flag_in;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  mflags;

    always #5 clk = ~clk;

    alu_ctrl #(.W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_cond  (req_cond),
        .req_s     (req_s),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shc   (req_shc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_cin   (alu_cin),
        .alu_r     (alu_r),
        .alu_flag  (alu_flag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_wr    (res_wr),
        .flags     (flags),
        .flag_ld   (flag_ld),
        .flag_in   (flag_in)
    );

    // Behavioural ALU, returns {C,Z,V,N, result}. Subtract C is a borrow.
    // Logical ops report C=V=1 and undefined ops report all flags set, so a
    // controller that wrongly loads them is exposed.
    function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [32:0] t;
        logic [31:0] r;
        logic        c, v;
        t = '0; c = 1'b1; v = 1'b1;
        case (op)
            5'd0, 5'd8: r = a & b;
            5'd1, 5'd9: r = a ^ b;
            5'd12:      r = a | b;
            5'd13:      r = a;
            5'd14:      r = b & ~a;
            5'd15:      r = ~a;
            5'd2, 5'd10, 5'd6: begin
                t = {1'b0, b} - {1'b0, a} - ((op == 5'd6) ? {32'd0, cin} : 33'd0);
                r = t[31:0]; c = t[32];
                v = (b[31] != a[31]) && (r[31] != b[31]);
            end
            5'd3, 5'd7: begin
                t = {1'b0, a} - {1'b0, b} - ((op == 5'd7) ? {32'd0, cin} : 33'd0);
                r = t[31:0]; c = t[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            5'd4, 5'd11, 5'd5: begin
                t = {1'b0, b} + {1'b0, a} + ((op == 5'd5) ? {32'd0, cin} : 33'd0);
                r = t[31:0]; c = t[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: return {4'b1111, a + b};
        endcase
        return {c, (r == 32'd0), v, r[31], r};
    endfunction

    assign {alu_flag, alu_r} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {c, z, v, n} = f;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_flags(input logic [3:0] v);
        @(negedge clk);
        flag_ld = 1'b1; flag_in = v;
        @(negedge clk);
        flag_ld = 1'b0;
        mflags = v;
        check("flag_load", flags, v);
    endtask

    task automatic run(input logic [4:0] op, input logic [3:0] cond, input logic s,
                       input logic [31:0] a, input logic [31:0] b, input logic shc,
                       input int hold, input logic ld, input logic [3:0] ld_val,
                       input logic rst_done);
        logic        p, cmpop;
        logic [35:0] ar;
        logic [3:0]  exp_f;
        logic [31:0] exp_d;
        logic        exp_wr;
        @(negedge clk);
        check("idle_ready", req_ready, 1);
        check("idle_alu_op", alu_op, 5'b10000);
        check("idle_alu_a", alu_a | alu_b | alu_cin, 0);
        req_valid = 1'b1; req_op = op; req_cond = cond; req_s = s;
        req_a = a; req_b = b; req_shc = shc;

        p      = cond_ok(cond, mflags);
        cmpop  = op inside {5'd8, 5'd9, 5'd10, 5'd11};
        ar     = alu_fn(op, a, b, mflags[3]);
        exp_d  = ar[31:0];
        exp_wr = p && !cmpop;
        exp_f  = mflags;
        if (op < 5'd16 && p && (s || cmpop)) begin
            if (op inside {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11})
                exp_f = ar[35:32];
            else
                exp_f = {shc, ar[34], mflags[1], ar[32]};
        end
        if (ld) exp_f = ld_val;

        @(negedge clk);
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_op = 5'($urandom); req_shc = ~shc;
        check("exec_res_valid", res_valid, 0);
        check("exec_req_ready", req_ready, 0);
        check("exec_alu_op", alu_op, op);
        check("exec_alu_a", alu_a, a);
        check("exec_alu_b", alu_b, b);
        check("exec_alu_cin", alu_cin, mflags[3]);
        if (ld) begin flag_ld = 1'b1; flag_in = ld_val; end

        @(negedge clk);
        flag_ld = 1'b0;
        check("done_res_valid", res_valid, 1);
        check("done_res_data", res_data, exp_d);
        check("done_res_wr", res_wr, exp_wr);
        check("done_flags", flags, exp_f);
        check("done_req_ready", req_ready, 0);
        check("done_alu_op", alu_op, 5'b10000);
        mflags = exp_f;

        if (rst_done) begin
            reset = 1'b1;
            #1;
            check("rst_res_valid", res_valid, 0);
            check("rst_flags", flags, 0);
            check("rst_res_data", res_data, 0);
            check("rst_res_wr", res_wr, 0);
            @(negedge clk);
            reset = 1'b0;
            mflags = 4'b0000;
            return;
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_res_valid", res_valid, 1);
            check("hold_res_data", res_data, exp_d);
            check("hold_res_wr", res_wr, exp_wr);
            check("hold_req_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("ret_res_valid", res_valid, 0);
        check("ret_req_ready", req_ready, 1);
        check("ret_flags", flags, exp_f);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_cond = '0; req_s = 1'b0;
        req_a = '0; req_b = '0; req_shc = 1'b0; res_ready = 1'b0;
        flag_ld = 1'b0; flag_in = '0; mflags = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset_flags", flags, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_data", res_data, 0);
        check("reset_res_wr", res_wr, 0);
        check("reset_alu_op", alu_op, 5'b10000);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1);

        run(OP_ADD, COND_AL, 1'b1, 32'd1, 32'd2, 1'b0, 0, 1'b0, 4'h0, 1'b0);
        check("add_data", res_data, 32'd3);
        check("add_wr", res_wr, 1);
        check("add_flags", flags, 4'b0000);

        run(OP_CMP, COND_AL, 1'b0, 32'd5, 32'd5, 1'b0, 0, 1'b0, 4'h0, 1'b0);
        check("cmp_data", res_data, 32'd0);
        check("cmp_wr", res_wr, 0);
        check("cmp_flags", flags, 4'b0100);

        run(OP_ADD, COND_NE, 1'b0, 32'd1, 32'd1, 1'b0, 0, 1'b0, 4'h0, 1'b0);
        check("ne_wr", res_wr, 0);
        check("ne_flags", flags, 4'b0100);
        run(OP_ADD, COND_EQ, 1'b0, 32'd1, 32'd1, 1'b0, 0, 1'b0, 4'h0, 1'b0);
        check("eq_wr", res_wr, 1);
        check("eq_data", res_data, 32'd2);

        load_flags(4'b0010);
        run(OP_MOV, COND_AL, 1'b1, 32'h8000_0000, 32'h1234_5678, 1'b1, 0, 1'b0, 4'h0, 1'b0);
        check("mov_flags", flags, 4'b1011);

        run(OP_ADD, COND_AL, 1'b1, 32'd7, 32'd9, 1'b0, 5, 1'b1, 4'b1111, 1'b0);
        check("ld_prio_flags", flags, 4'b1111);

        run(5'b10001, COND_AL, 1'b1, 32'd3, 32'd4, 1'b0, 1, 1'b0, 4'h0, 1'b0);
        check("undef_flags", flags, 4'b1111);
        check("undef_wr", res_wr, 1);

        load_flags(4'b0000);
        run(OP_ADC, COND_NV, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b0, 4'h0, 1'b0);
        check("nv_wr", res_wr, 0);
        check("nv_flags", flags, 4'b0000);

        run(OP_SUB, COND_AL, 1'b1, 32'd9, 32'd2, 1'b0, 0, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        check("rst_mid_ready", req_ready, 1);
        run(OP_ADD, COND_AL, 1'b1, 32'd10, 32'd20, 1'b0, 0, 1'b0, 4'h0, 1'b0);
        check("after_rst_data", res_data, 32'd30);

        for (int k = 0; k < 60; k++) begin
            logic [4:0]  op;
            logic [3:0]  cond;
            logic [31:0] a, b;
            if ($urandom_range(0, 4) == 0) load_flags(4'($urandom));
            op   = 5'($urandom_range(0, 19));
            cond = ($urandom_range(0, 3) == 0) ? COND_AL : 4'($urandom);
            a    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run(op, cond, 1'($urandom), a, b, 1'($urandom), $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0), 4'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
